// File: rtl/mc_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mc_controller : multicycle ARM control unit (main FSM, ALU decode, NZCV)  |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mc_controller (
  input  logic         clk,
  input  logic         reset,
  input  logic [31:12] Instr,
  input  logic [3:0]   ALUFlags,
  output logic         PCWrite,
  output logic         MemWrite,
  output logic         RegWrite,
  output logic         IRWrite,
  output logic         AdrSrc,
  output logic [1:0]   RegSrc,
  output logic [1:0]   ALUSrcA,
  output logic [1:0]   ALUSrcB,
  output logic [1:0]   ResultSrc,
  output logic [1:0]   ImmSrc,
  output logic [1:0]   ALUControl
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXECR  = 4'd2,
    S_EXECI  = 4'd3,
    S_ALUWB  = 4'd4,
    S_MEMADR = 4'd5,
    S_MEMRD  = 4'd6,
    S_MEMWB  = 4'd7,
    S_MEMWR  = 4'd8,
    S_BRANCH = 4'd9
  } state_t;

  typedef struct packed {
    logic       next_pc;
    logic       irw;
    logic       adr_src;
    logic       reg_w;
    logic       mem_w;
    logic       branch;
    logic       alu_op;
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic [1:0] res_src;
  } ctrl_t;

  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic       unused_rn;

  assign cond      = Instr[31:28];
  assign op        = Instr[27:26];
  assign funct     = Instr[25:20];
  assign rd        = Instr[15:12];
  assign unused_rn = ^Instr[19:16];

  function automatic ctrl_t decode_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:  begin c.next_pc = 1'b1; c.irw = 1'b1; c.src_a = 2'b01; c.src_b = 2'b10; c.res_src = 2'b10; end
      S_DECODE: begin c.src_a = 2'b01; c.src_b = 2'b10; c.res_src = 2'b10; end
      S_EXECR:  begin c.alu_op = 1'b1; end
      S_EXECI:  begin c.alu_op = 1'b1; c.src_b = 2'b01; end
      S_ALUWB:  begin c.reg_w = 1'b1; end
      S_MEMADR: begin c.src_b = 2'b01; end
      S_MEMRD:  begin c.adr_src = 1'b1; end
      S_MEMWB:  begin c.res_src = 2'b01; c.reg_w = 1'b1; end
      S_MEMWR:  begin c.adr_src = 1'b1; c.mem_w = 1'b1; end
      S_BRANCH: begin c.src_a = 2'b10; c.src_b = 2'b01; c.res_src = 2'b10; c.branch = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  function automatic state_t next_state(input state_t s, input logic [1:0] o, input logic [5:0] f);
    state_t n;
    case (s)
      S_FETCH:  n = S_DECODE;
      S_DECODE: begin
        case (o)
          2'b00:   n = f[5] ? S_EXECI : S_EXECR;
          2'b01:   n = S_MEMADR;
          2'b10:   n = S_BRANCH;
          default: n = S_FETCH;
        endcase
      end
      S_EXECR, S_EXECI: n = S_ALUWB;
      S_MEMADR: n = f[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  n = S_MEMWB;
      default:  n = S_FETCH;
    endcase
    return n;
  endfunction

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    logic r;
    {n, z, cy, v} = f;
    case (c)
      4'h0:    r = z;
      4'h1:    r = ~z;
      4'h2:    r = cy;
      4'h3:    r = ~cy;
      4'h4:    r = n;
      4'h5:    r = ~n;
      4'h6:    r = v;
      4'h7:    r = ~v;
      4'h8:    r = cy & ~z;
      4'h9:    r = ~cy | z;
      4'hA:    r = ~(n ^ v);
      4'hB:    r = n ^ v;
      4'hC:    r = ~z & ~(n ^ v);
      4'hD:    r = z | (n ^ v);
      4'hE:    r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  state_t     state;
  state_t     nxt;
  ctrl_t      ctrl;
  logic [3:0] flags;
  logic       condex_q;
  logic       nowrite_q;
  logic       condex;
  logic [1:0] alu_ctl;
  logic [1:0] flag_w;
  logic       nowrite;
  logic       arith;
  logic       known;
  logic       pcs;

  assign nxt    = next_state(state, op, funct);
  assign condex = cond_holds(cond, flags);

  // ALU command decode is only meaningful in the execute states; elsewhere the ALU adds.
  always_comb begin
    alu_ctl = 2'b00;
    arith   = 1'b0;
    known   = 1'b0;
    nowrite = 1'b0;
    if (ctrl.alu_op) begin
      known = 1'b1;
      case (funct[4:1])
        4'b0100: begin alu_ctl = 2'b00; arith = 1'b1; end
        4'b0010: begin alu_ctl = 2'b01; arith = 1'b1; end
        4'b0000: alu_ctl = 2'b10;
        4'b1100: alu_ctl = 2'b11;
        4'b1010: begin alu_ctl = 2'b01; arith = 1'b1; nowrite = 1'b1; end
        default: begin known = 1'b0; nowrite = 1'b1; end
      endcase
    end
    flag_w = known ? {funct[0], funct[0] & arith} : 2'b00;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_FETCH;
      ctrl      <= decode_ctrl(S_FETCH);
      flags     <= 4'b0000;
      condex_q  <= 1'b0;
      nowrite_q <= 1'b0;
    end else begin
      state     <= nxt;
      ctrl      <= decode_ctrl(nxt);
      nowrite_q <= nowrite;
      if (state == S_DECODE) condex_q <= condex;
      // condex_q still holds this instruction's decision, so its own flag write cannot gate itself
      if (ctrl.alu_op && condex_q) begin
        if (flag_w[1]) flags[3:2] <= ALUFlags[3:2];
        if (flag_w[0]) flags[1:0] <= ALUFlags[1:0];
      end
    end
  end

  assign pcs        = ((rd == 4'd15) & ctrl.reg_w) | ctrl.branch;
  assign PCWrite    = reset & (ctrl.next_pc | (pcs & condex_q));
  assign RegWrite   = reset & ctrl.reg_w & condex_q & ~nowrite_q;
  assign MemWrite   = reset & ctrl.mem_w & condex_q;
  assign IRWrite    = reset & ctrl.irw;
  assign AdrSrc     = ctrl.adr_src;
  assign ALUSrcA    = ctrl.src_a;
  assign ALUSrcB    = ctrl.src_b;
  assign ResultSrc  = ctrl.res_src;
  assign ALUControl = alu_ctl;
  assign ImmSrc     = op;
  assign RegSrc     = {op == 2'b01, op == 2'b10};

endmodule
`default_nettype wire

// File: tb/tb_mc_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mc_controller : randomized self-checking bench for mc_controller       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_mc_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;
  logic        PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
  logic [1:0]  RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .MemWrite(MemWrite), .RegWrite(RegWrite), .IRWrite(IRWrite),
    .AdrSrc(AdrSrc), .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
  );

  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  mflags = 4'b0000;
  logic [3:0]  cur_aux;
  logic [16:0] exp_q[$];
  logic [16:0] msk_q[$];
  logic [16:0] obs_q[$];

  function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c)
      0: return z;          1: return !z;
      2: return cy;         3: return !cy;
      4: return n;          5: return !n;
      6: return v;          7: return !v;
      8: return cy && !z;   9: return !cy || z;
      10: return n == v;    11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // One expected cycle: enables, selects, and which selects the cycle pins down ({adr,A,B,Res}).
  function automatic void push(input logic [3:0] en, input logic adr, input logic [1:0] a,
                               input logic [1:0] b, input logic [1:0] r, input logic [1:0] alu,
                               input logic [3:0] m);
    exp_q.push_back({en, adr, a, b, r, alu, cur_aux});
    msk_q.push_back({4'hF, m[3], {2{m[2]}}, {2{m[1]}}, {2{m[0]}}, 2'b11, 4'hF});
  endfunction

  // Per-instruction cycle sequence derived from the instruction class, plus flag update.
  function automatic void model(input logic [19:0] iw, input logic [3:0] af);
    logic [3:0] cnd, rd;
    logic [1:0] op, ctl;
    logic [5:0] fn;
    logic       ok, pc15, arith, known, wr;
    cnd = iw[19:16]; op = iw[15:14]; fn = iw[13:8]; rd = iw[3:0];
    ok = cond_pass(cnd, mflags);
    pc15 = ok && (rd == 4'd15);
    cur_aux = {op == 2'b01, op == 2'b10, op};
    exp_q.delete(); msk_q.delete();
    push(4'b1001, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 4'b1111);
    push(4'b0000, 1'b0, 2'b01, 2'b10, 2'b10, 2'b00, 4'b0111);
    case (op)
      2'b00: begin
        ctl = 2'b00; arith = 1'b0; known = 1'b1; wr = 1'b1;
        case (fn[4:1])
          4'b0100: begin ctl = 2'b00; arith = 1'b1; end
          4'b0010: begin ctl = 2'b01; arith = 1'b1; end
          4'b0000: ctl = 2'b10;
          4'b1100: ctl = 2'b11;
          4'b1010: begin ctl = 2'b01; arith = 1'b1; wr = 1'b0; end
          default: begin known = 1'b0; wr = 1'b0; end
        endcase
        push(4'b0000, 1'b0, 2'b00, fn[5] ? 2'b01 : 2'b00, 2'b00, ctl, 4'b0110);
        push({pc15, ok && wr, 2'b00}, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0001);
        if (ok && known && fn[0]) begin
          mflags[3:2] = af[3:2];
          if (arith) mflags[1:0] = af[1:0];
        end
      end
      2'b01: begin
        push(4'b0000, 1'b0, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0110);
        if (fn[0]) begin
          push(4'b0000, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1001);
          push({pc15, ok, 2'b00}, 1'b0, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0001);
        end else begin
          push({2'b00, ok, 1'b0}, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1001);
        end
      end
      2'b10: push({ok, 3'b000}, 1'b0, 2'b10, 2'b01, 2'b10, 2'b00, 4'b0111);
      default: ;
    endcase
  endfunction

  function automatic logic [16:0] sample();
    return {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB,
            ResultSrc, ALUControl, RegSrc, ImmSrc};
  endfunction

  // Entered during a FETCH cycle before its falling edge; leaves in the next FETCH.
  task automatic run(input logic [31:0] w, input logic [3:0] af);
    model(w[31:12], af);
    Instr = w[31:12];
    ALUFlags = af;
    obs_q.delete();
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      obs_q.push_back(sample());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if ({PCWrite, RegWrite, MemWrite, IRWrite} !== 4'b0000) begin
        miscompares++;
        $display("FAIL reset_enables: got %b want 0000", {PCWrite, RegWrite, MemWrite, IRWrite});
      end
    end
    @(posedge clk); #1;
    reset = 1'b1;
    mflags = 4'b0000;
    run(32'hE3500005, 4'b0100);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        miscompares++;
        $display("FAIL reset_cmp cycle %0d: got %b want %b mask %b", i, obs_q[i], exp_q[i], msk_q[i]);
      end
    end
    Instr = 20'hE5910;
    ALUFlags = 4'b0000;
    repeat (3) begin @(negedge clk); @(posedge clk); #1; end
    @(negedge clk);
    vectors++;
    if (AdrSrc !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_memrd_adrsrc: got %b want 1", AdrSrc);
    end
    #1 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc} !== 11'b0000_0_01_10_10) begin
        miscompares++;
        $display("FAIL reset_hold: got %b want 00000011010",
                 {PCWrite, RegWrite, MemWrite, IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc});
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    mflags = 4'b0000;
    run(32'h0A000002, 4'b0100);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        miscompares++;
        $display("FAIL reset_beq cycle %0d: got %b want %b mask %b", i, obs_q[i], exp_q[i], msk_q[i]);
      end
    end
  endtask

  task automatic test_add();
    run(32'hE0821003, 4'($urandom));
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        miscompares++;
        $display("FAIL add cycle %0d: got %b want %b mask %b", i, obs_q[i], exp_q[i], msk_q[i]);
      end
    end
    vectors++;
    if (obs_q[3][15] !== 1'b1) begin
      miscompares++;
      $display("FAIL add_regwrite: got %b want 1", obs_q[3][15]);
    end
  endtask

  task automatic test_ldr();
    run(32'hE5910004, 4'($urandom));
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        miscompares++;
        $display("FAIL ldr cycle %0d: got %b want %b mask %b", i, obs_q[i], exp_q[i], msk_q[i]);
      end
    end
  endtask

  task automatic test_subs_beq();
    logic [3:0] af_set[2];
    af_set[0] = 4'b0100;
    af_set[1] = 4'b0000;
    for (int k = 0; k < 2; k++) begin
      run(32'hE2500001, af_set[k]);
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
          miscompares++;
          $display("FAIL subs%0d cycle %0d: got %b want %b mask %b", k, i, obs_q[i], exp_q[i], msk_q[i]);
        end
      end
      run(32'h0A000002, 4'($urandom));
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
          miscompares++;
          $display("FAIL beq%0d cycle %0d: got %b want %b mask %b", k, i, obs_q[i], exp_q[i], msk_q[i]);
        end
      end
      vectors++;
      if (obs_q[2][16] !== (k == 0)) begin
        miscompares++;
        $display("FAIL beq%0d_pcwrite: got %b want %b", k, obs_q[2][16], k == 0);
      end
    end
  endtask

  task automatic test_cmp();
    run(32'hE3500005, 4'($urandom));
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        miscompares++;
        $display("FAIL cmp cycle %0d: got %b want %b mask %b", i, obs_q[i], exp_q[i], msk_q[i]);
      end
    end
    run(32'h0A000002, 4'b0000);
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
        miscompares++;
        $display("FAIL cmp_beq cycle %0d: got %b want %b mask %b", i, obs_q[i], exp_q[i], msk_q[i]);
      end
    end
  endtask

  task automatic test_strne_op11();
    logic [31:0] words[3];
    words[0] = 32'hE3500005;
    words[1] = 32'h15810000;
    words[2] = 32'hEC000000;
    for (int k = 0; k < 3; k++) begin
      run(words[k], (k == 0) ? 4'b0100 : 4'($urandom));
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
          miscompares++;
          $display("FAIL strne_op11 word%0d cycle %0d: got %b want %b mask %b", k, i, obs_q[i], exp_q[i], msk_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  cmds[6];
    logic [31:0] w;
    logic [3:0]  cnd, rd, cmd;
    logic [5:0]  fn;
    logic [1:0]  op;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010;
    for (int n = 0; n < 80; n++) begin
      op  = 2'($urandom_range(0, 3));
      cnd = ($urandom_range(0, 9) == 0) ? 4'hF : 4'($urandom_range(0, 14));
      rd  = ($urandom_range(0, 4) == 0) ? 4'd15 : 4'($urandom);
      fn  = 6'($urandom);
      if (op == 2'b00) begin
        cmds[5] = 4'($urandom);
        cmd = cmds[$urandom_range(0, 5)];
        fn[4:1] = cmd;
        if (cmd == 4'b1010) fn[0] = 1'b1;
      end
      w = {cnd, op, fn, 4'($urandom), rd, 12'($urandom)};
      run(w, 4'($urandom));
      for (int i = 0; i < exp_q.size(); i++) begin
        vectors++;
        if ((obs_q[i] & msk_q[i]) !== (exp_q[i] & msk_q[i])) begin
          miscompares++;
          $display("FAIL random #%0d instr %h cycle %0d: got %b want %b mask %b", n, w, i, obs_q[i], exp_q[i], msk_q[i]);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_ldr();
    test_subs_beq();
    test_cmp();
    test_strne_op11();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
